// File: rtl/dstack_issue_pkg.sv
// dstack_issue_pkg: shared types for the dstack issue stage.
//   op_t     : decoder operation codes (4 bits)
//   S_*      : dstack movement encodings
//   state_t  : DROPN sequencer states
package dstack_issue_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_PUSH  = 4'd1,
    OP_DUP   = 4'd2,
    OP_DROP  = 4'd3,
    OP_DROP2 = 4'd4,
    OP_ADD   = 4'd5,
    OP_SUB   = 4'd6,
    OP_COPY  = 4'd7,
    OP_ROT   = 4'd8,
    OP_SWAP  = 4'd9,
    OP_DROPN = 4'd10
  } op_t;

  localparam logic [1:0] S_NOTHING   = 2'b00;
  localparam logic [1:0] S_PUSH_ONCE = 2'b01;
  localparam logic [1:0] S_POP_ONCE  = 2'b10;
  localparam logic [1:0] S_POP_TWICE = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    DROP = 1'b1
  } state_t;

endpackage

// File: rtl/dstack_issue_if.sv
// dstack_issue_if: decoder -> issue-stage operation handshake.
//   op_valid  : decoder presents an operation
//   op_ready  : issue stage can accept this cycle
//   op_code   : operation (op_t)
//   op_imm    : PUSH immediate
//   op_addr   : COPY/ROT element index (0 = second)
//   op_count  : DROPN element count
// master = decoder side, slave = issue stage.
interface dstack_issue_if import dstack_issue_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_MAG = 7,
  parameter int ROT_MAG   = 6
) ();

  logic                 op_valid;
  logic                 op_ready;
  op_t                  op_code;
  logic [WIDTH-1:0]     op_imm;
  logic [ROT_MAG-1:0]   op_addr;
  logic [DEPTH_MAG-1:0] op_count;

  modport master (
    output op_valid, op_code, op_imm, op_addr, op_count,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_code, op_imm, op_addr, op_count,
    output op_ready
  );

endinterface

// File: rtl/dstack_issue_need.sv
// dstack_issue_need: combinational legality check for one operation.
//   op_code/op_addr/op_count : operation under test
//   depth                    : current stack depth
//   underflow                : op needs more elements than present
//   overflow                 : op pushes while the stack is full
module dstack_issue_need import dstack_issue_pkg::*; #(
  parameter int DEPTH_MAG = 7,
  parameter int DEPTH     = 65,
  parameter int ROT_MAG   = 6
) (
  input  op_t                  op_code,
  input  logic [ROT_MAG-1:0]   op_addr,
  input  logic [DEPTH_MAG-1:0] op_count,
  input  logic [DEPTH_MAG-1:0] depth,
  output logic                 underflow,
  output logic                 overflow
);

  // Wide enough for op_addr + 2 and for any depth value without wrap.
  localparam int NW = ((DEPTH_MAG > ROT_MAG) ? DEPTH_MAG : ROT_MAG) + 2;
  localparam logic [NW-1:0] FULL = NW'(DEPTH);

  logic [NW-1:0] need;
  logic          pushes;

  always_comb begin
    need   = '0;
    pushes = 1'b0;
    case (op_code)
      OP_PUSH:  pushes = 1'b1;
      OP_DUP:   begin need = NW'(1); pushes = 1'b1; end
      OP_DROP:  need = NW'(1);
      OP_DROP2,
      OP_ADD,
      OP_SUB,
      OP_SWAP:  need = NW'(2);
      OP_COPY:  begin need = NW'(op_addr) + NW'(2); pushes = 1'b1; end
      OP_ROT:   need = NW'(op_addr) + NW'(2);
      OP_DROPN: need = NW'(op_count);
      default:  ;
    endcase
    underflow = (need > NW'(depth));
    // Underflow takes priority so a single op never raises both flags.
    overflow  = pushes && !underflow && (NW'(depth) >= FULL);
  end

endmodule

// File: rtl/dstack_issue.sv
// dstack_issue: issue stage in front of dstack.
//   clk, reset      : clock, asynchronous active-high reset
//   op              : decoder handshake (slave modport)
//   ds_movement     : 00 nothing, 01 push, 10 pop once, 11 pop twice
//   ds_new_top      : value written as the new top of stack
//   ds_rot_addr     : element index for COPY/ROT
//   ds_rotate       : rotate command
//   ds_top/second/third/rot_val : current dstack contents
//   ds_overflow     : dstack overflow, mirrored onto err_overflow
//   depth           : live element count
//   err_underflow   : one-cycle pulse after an underflow rejection
//   err_overflow    : pulse after a rejected push at full, or ds_overflow
module dstack_issue import dstack_issue_pkg::*; #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_MAG = 7,
  parameter int DEPTH     = 65,
  parameter int ROT_MAG   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  dstack_issue_if.slave        op,
  output logic [1:0]           ds_movement,
  output logic [WIDTH-1:0]     ds_new_top,
  output logic [ROT_MAG-1:0]   ds_rot_addr,
  output logic                 ds_rotate,
  input  logic [WIDTH-1:0]     ds_top,
  input  logic [WIDTH-1:0]     ds_second,
  input  logic [WIDTH-1:0]     ds_third,
  input  logic [WIDTH-1:0]     ds_rot_val,
  input  logic                 ds_overflow,
  output logic [DEPTH_MAG-1:0] depth,
  output logic                 err_underflow,
  output logic                 err_overflow
);

  state_t               state, next_state;
  logic [DEPTH_MAG-1:0] remaining, next_remaining, next_depth;
  logic                 accept, underflow, overflow;
  logic                 err_underflow_q, err_overflow_q;

  dstack_issue_need #(
    .DEPTH_MAG (DEPTH_MAG),
    .DEPTH     (DEPTH),
    .ROT_MAG   (ROT_MAG)
  ) u_need (
    .op_code   (op.op_code),
    .op_addr   (op.op_addr),
    .op_count  (op.op_count),
    .depth     (depth),
    .underflow (underflow),
    .overflow  (overflow)
  );

  assign op.op_ready = (state == IDLE);
  assign accept      = op.op_valid && op.op_ready;

  always_comb begin
    ds_movement    = S_NOTHING;
    ds_new_top     = '0;
    ds_rot_addr    = '0;
    ds_rotate      = 1'b0;
    next_state     = state;
    next_remaining = remaining;
    case (state)
      IDLE: begin
        // A rejected op is still consumed but issues nothing.
        if (accept && !underflow && !overflow) begin
          case (op.op_code)
            OP_PUSH:  begin ds_movement = S_PUSH_ONCE; ds_new_top = op.op_imm; end
            OP_DUP:   begin ds_movement = S_PUSH_ONCE; ds_new_top = ds_top; end
            OP_DROP:  begin ds_movement = S_POP_ONCE;  ds_new_top = ds_second; end
            OP_DROP2: begin ds_movement = S_POP_TWICE; ds_new_top = ds_third; end
            OP_ADD:   begin ds_movement = S_POP_ONCE;  ds_new_top = ds_top + ds_second; end
            OP_SUB:   begin ds_movement = S_POP_ONCE;  ds_new_top = ds_second - ds_top; end
            OP_COPY: begin
              ds_movement = S_PUSH_ONCE;
              ds_rot_addr = op.op_addr;
              ds_new_top  = ds_rot_val;
            end
            OP_ROT: begin
              ds_rotate   = 1'b1;
              ds_rot_addr = op.op_addr;
              ds_new_top  = ds_rot_val;
            end
            OP_SWAP: begin
              ds_rotate   = 1'b1;
              ds_new_top  = ds_rot_val;
            end
            OP_DROPN: begin
              if (op.op_count == DEPTH_MAG'(1)) begin
                ds_movement = S_POP_ONCE;
                ds_new_top  = ds_second;
              end else if (op.op_count >= DEPTH_MAG'(2)) begin
                ds_movement = S_POP_TWICE;
                ds_new_top  = ds_third;
                if (op.op_count >= DEPTH_MAG'(3)) begin
                  // remaining counts what is left after this cycle's pop-twice.
                  next_state     = DROP;
                  next_remaining = op.op_count - DEPTH_MAG'(2);
                end
              end
            end
            default: ;
          endcase
        end
      end
      DROP: begin
        if (remaining >= DEPTH_MAG'(2)) begin
          ds_movement    = S_POP_TWICE;
          ds_new_top     = ds_third;
          next_remaining = remaining - DEPTH_MAG'(2);
        end else begin
          ds_movement    = S_POP_ONCE;
          ds_new_top     = ds_second;
          next_remaining = '0;
        end
        if (remaining <= DEPTH_MAG'(2)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    next_depth = depth;
    case (ds_movement)
      S_PUSH_ONCE: next_depth = depth + DEPTH_MAG'(1);
      S_POP_ONCE:  next_depth = depth - DEPTH_MAG'(1);
      S_POP_TWICE: next_depth = depth - DEPTH_MAG'(2);
      default:     next_depth = depth;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      depth           <= '0;
      remaining       <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      state           <= next_state;
      depth           <= next_depth;
      remaining       <= next_remaining;
      err_underflow_q <= accept && underflow;
      err_overflow_q  <= accept && overflow;
    end
  end

  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q || ds_overflow;

endmodule

// File: tb/tb_dstack_issue.sv
// tb_dstack_issue: directed bench for dstack_issue. A queue stands in for
// dstack: it is updated from the DUT's movement/new_top/rotate commands and
// feeds ds_top/second/third/rot_val back to the DUT.
module tb_dstack_issue;
  import dstack_issue_pkg::*;

  localparam int WIDTH     = 32;
  localparam int DEPTH_MAG = 7;
  localparam int DEPTH     = 65;
  localparam int ROT_MAG   = 6;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           ds_movement;
  logic [WIDTH-1:0]     ds_new_top;
  logic [ROT_MAG-1:0]   ds_rot_addr;
  logic                 ds_rotate;
  logic [WIDTH-1:0]     ds_top, ds_second, ds_third, ds_rot_val;
  logic                 ds_overflow;
  logic [DEPTH_MAG-1:0] depth;
  logic                 err_underflow, err_overflow;

  dstack_issue_if #(.WIDTH(WIDTH), .DEPTH_MAG(DEPTH_MAG), .ROT_MAG(ROT_MAG)) opif ();

  dstack_issue #(
    .WIDTH(WIDTH), .DEPTH_MAG(DEPTH_MAG), .DEPTH(DEPTH), .ROT_MAG(ROT_MAG)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (opif),
    .ds_movement   (ds_movement),
    .ds_new_top    (ds_new_top),
    .ds_rot_addr   (ds_rot_addr),
    .ds_rotate     (ds_rotate),
    .ds_top        (ds_top),
    .ds_second     (ds_second),
    .ds_third      (ds_third),
    .ds_rot_val    (ds_rot_val),
    .ds_overflow   (ds_overflow),
    .depth         (depth),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0]   q[$];
  int                 checks = 0;
  int                 errors = 0;
  logic [1:0]         s_mov;
  logic [WIDTH-1:0]   s_top;
  logic               s_rot;
  logic [ROT_MAG-1:0] s_addr;
  logic               s_ready;
  logic [WIDTH-1:0]   exp_copy;
  logic [1:0]         exp_mov[3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_ds();
    int idx;
    idx        = int'(opif.op_addr) + 1;
    ds_top     = (q.size() > 0) ? q[0] : '0;
    ds_second  = (q.size() > 1) ? q[1] : '0;
    ds_third   = (q.size() > 2) ? q[2] : '0;
    ds_rot_val = (idx < q.size()) ? q[idx] : '0;
  endtask

  task automatic apply_model();
    int idx;
    if (reset) begin
      q.delete();
    end else if (s_rot) begin
      idx = int'(s_addr) + 1;
      if (idx < q.size()) begin
        q.delete(idx);
        q.push_front(s_top);
      end
    end else begin
      case (s_mov)
        2'b01: q.push_front(s_top);
        2'b10: begin
          if (q.size() > 0) void'(q.pop_front());
          if (q.size() > 0) q[0] = s_top;
        end
        2'b11: begin
          if (q.size() > 0) void'(q.pop_front());
          if (q.size() > 0) void'(q.pop_front());
          if (q.size() > 0) q[0] = s_top;
        end
        default: ;
      endcase
    end
  endtask

  // One clock: sample combinational outputs, let dstack commit on the edge.
  task automatic tick();
    refresh_ds();
    #1;
    s_mov   = ds_movement;
    s_top   = ds_new_top;
    s_rot   = ds_rotate;
    s_addr  = ds_rot_addr;
    s_ready = opif.op_ready;
    @(posedge clk);
    apply_model();
    @(negedge clk);
    refresh_ds();
  endtask

  task automatic do_op(input op_t c, input logic [WIDTH-1:0] imm,
                       input logic [ROT_MAG-1:0] a, input logic [DEPTH_MAG-1:0] n);
    opif.op_valid = 1'b1;
    opif.op_code  = c;
    opif.op_imm   = imm;
    opif.op_addr  = a;
    opif.op_count = n;
    tick();
    opif.op_valid = 1'b0;
    opif.op_code  = OP_NOP;
    opif.op_imm   = '0;
    opif.op_addr  = '0;
    opif.op_count = '0;
    refresh_ds();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    q.delete();
    reset = 1'b0;
    refresh_ds();
  endtask

  initial begin
    reset         = 1'b1;
    ds_overflow   = 1'b0;
    opif.op_valid = 1'b0;
    opif.op_code  = OP_NOP;
    opif.op_imm   = '0;
    opif.op_addr  = '0;
    opif.op_count = '0;
    refresh_ds();

    // Reset values
    @(negedge clk);
    check("rst_ready", opif.op_ready, 1);
    check("rst_depth", depth, 0);
    check("rst_mov", ds_movement, 0);
    check("rst_new_top", ds_new_top, 0);
    check("rst_rotate", ds_rotate, 0);
    check("rst_rot_addr", ds_rot_addr, 0);
    check("rst_err_u", err_underflow, 0);
    check("rst_err_o", err_overflow, 0);
    reset = 1'b0;

    // PUSH 2, PUSH 8, ADD
    do_op(OP_PUSH, 2, 0, 0);
    do_op(OP_PUSH, 8, 0, 0);
    check("push_top", ds_top, 8);
    check("push_second", ds_second, 2);
    check("push_depth", depth, 2);
    do_op(OP_ADD, 0, 0, 0);
    check("add_mov", s_mov, 2'b10);
    check("add_new_top", s_top, 10);
    check("add_top", ds_top, 10);
    check("add_depth", depth, 1);

    // ROT / COPY / SWAP
    do_op(OP_PUSH, 33, 0, 0);
    do_op(OP_PUSH, 57, 0, 0);
    do_op(OP_PUSH, 77, 0, 0);
    do_op(OP_PUSH, 79, 0, 0);
    check("push4_depth", depth, 5);
    do_op(OP_ROT, 0, 1, 0);
    check("rot_mov", s_mov, 2'b00);
    check("rot_rotate", s_rot, 1);
    check("rot_addr", s_addr, 1);
    check("rot_top", ds_top, 57);
    check("rot_second", ds_second, 79);
    check("rot_depth", depth, 5);
    exp_copy = q[2];
    do_op(OP_COPY, 0, 1, 0);
    check("copy_mov", s_mov, 2'b01);
    check("copy_addr", s_addr, 1);
    check("copy_new_top", s_top, exp_copy);
    check("copy_depth", depth, 6);
    exp_copy = q[1];
    do_op(OP_SWAP, 0, 0, 0);
    check("swap_rotate", s_rot, 1);
    check("swap_addr", s_addr, 0);
    check("swap_new_top", s_top, exp_copy);
    check("swap_depth", depth, 6);

    // SUB wraps modulo 2^WIDTH: 3 - 5
    do_reset();
    check("rst2_depth", depth, 0);
    do_op(OP_PUSH, 3, 0, 0);
    do_op(OP_PUSH, 5, 0, 0);
    do_op(OP_SUB, 0, 0, 0);
    check("sub_new_top", s_top, 32'hFFFF_FFFE);
    check("sub_depth", depth, 1);
    do_op(OP_DROP, 0, 0, 0);
    check("drop_mov", s_mov, 2'b10);
    check("drop_depth", depth, 0);

    // DROP2 at depth 3, then underflow at depth 0
    do_op(OP_PUSH, 1, 0, 0);
    do_op(OP_PUSH, 2, 0, 0);
    do_op(OP_PUSH, 3, 0, 0);
    do_op(OP_DROP2, 0, 0, 0);
    check("drop2_mov", s_mov, 2'b11);
    check("drop2_new_top", s_top, 1);
    check("drop2_depth", depth, 1);
    do_op(OP_DROP, 0, 0, 0);
    check("drop1_depth", depth, 0);
    do_op(OP_DROP, 0, 0, 0);
    check("uf_ready", s_ready, 1);
    check("uf_mov", s_mov, 2'b00);
    check("uf_err", err_underflow, 1);
    check("uf_depth", depth, 0);
    tick();
    check("uf_err_clear", err_underflow, 0);

    // DROPN beyond depth is rejected; DROPN 2 is a plain DROP2
    do_op(OP_PUSH, 1, 0, 0);
    do_op(OP_PUSH, 2, 0, 0);
    do_op(OP_DROPN, 0, 0, 5);
    check("dropn_uf_mov", s_mov, 2'b00);
    check("dropn_uf_err", err_underflow, 1);
    check("dropn_uf_depth", depth, 2);
    do_op(OP_DROPN, 0, 0, 2);
    check("dropn2_mov", s_mov, 2'b11);
    check("dropn2_depth", depth, 0);
    check("dropn2_ready", opif.op_ready, 1);

    // DROPN 7 on 1..9
    do_reset();
    for (int i = 1; i <= 9; i++) do_op(OP_PUSH, WIDTH'(i), 0, 0);
    check("d7_pre_top", ds_top, 9);
    do_op(OP_DROPN, 0, 0, 7);
    check("d7_acc_mov", s_mov, 2'b11);
    check("d7_acc_new_top", s_top, 7);
    exp_mov[0] = 2'b11;
    exp_mov[1] = 2'b11;
    exp_mov[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("d7_ready_%0d", i), s_ready, 0);
      check($sformatf("d7_mov_%0d", i), s_mov, exp_mov[i]);
    end
    check("d7_ready_after", opif.op_ready, 1);
    check("d7_top", ds_top, 2);
    check("d7_depth", depth, 2);
    tick();
    check("d7_idle_mov", s_mov, 2'b00);

    // Overflow at full depth
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_op(OP_PUSH, WIDTH'(i + 100), 0, 0);
    check("full_depth", depth, DEPTH);
    do_op(OP_PUSH, 5, 0, 0);
    check("of_mov", s_mov, 2'b00);
    check("of_err", err_overflow, 1);
    check("of_depth", depth, DEPTH);
    check("of_top", ds_top, DEPTH - 1 + 100);
    tick();
    check("of_err_clear", err_overflow, 0);
    ds_overflow = 1'b1;
    #1;
    check("of_mirror", err_overflow, 1);
    ds_overflow = 1'b0;
    #1;
    check("of_mirror_clear", err_overflow, 0);

    // Reset during the second cycle of DROPN 9
    do_reset();
    for (int i = 1; i <= 9; i++) do_op(OP_PUSH, WIDTH'(i), 0, 0);
    do_op(OP_DROPN, 0, 0, 9);
    check("d9_acc_mov", s_mov, 2'b11);
    check("d9_busy", opif.op_ready, 0);
    reset = 1'b1;
    #1;
    check("d9_rst_ready", opif.op_ready, 1);
    check("d9_rst_depth", depth, 0);
    check("d9_rst_mov", ds_movement, 2'b00);
    @(posedge clk);
    @(negedge clk);
    q.delete();
    reset = 1'b0;
    tick();
    check("d9_after_mov", s_mov, 2'b00);
    check("d9_after_ready", s_ready, 1);
    check("d9_after_depth", depth, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
